// File: rtl/nibble_mac_seq_pkg.sv
// Shared types and constants for the nibble-serial multiply sequencer.
// Holds the FSM encoding, default pair counts and tile latency.
package nibble_mac_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int WIDTH_DEF = 32;
  localparam int NIB       = WIDTH_DEF / 4;
  localparam int PAIRS     = NIB * NIB;
  localparam int MUL_LAT   = 1;

  function automatic int pairs_for(input int w);
    return (w / 4) * (w / 4);
  endfunction

endpackage

// File: rtl/nibble_mac_seq.sv
// Streams nibble pairs through an external 4x4 registered tile and
// shift-adds the partial products into a 2*WIDTH accumulator.
module nibble_mac_seq
  import nibble_mac_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [3:0]         mul_a,
  output logic [3:0]         mul_b,
  input  logic [7:0]         mul_p
);

  localparam int NIBS  = WIDTH / 4;
  localparam int NPAIR = pairs_for(WIDTH);
  localparam int KW    = $clog2(NPAIR + 1);
  localparam int PW    = 2 * WIDTH;
  localparam int SW    = $clog2(PW);

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [MUL_LAT-1:0] vld_q;
  logic              vld_d;
  logic [SW-1:0]     sh_q [MUL_LAT];
  logic [SW-1:0]     sh_d;
  logic [KW-1:0]     i_w, j_w;
  logic [PW-1:0]     addend;

  assign product = prod_q;

  // Pair index decode and the aligned partial product.
  always_comb begin
    i_w    = k_q % KW'(NIBS);
    j_w    = k_q / KW'(NIBS);
    addend = '0;
    if (vld_q[MUL_LAT-1]) begin
      addend = PW'(mul_p) << sh_q[MUL_LAT-1];
    end
  end

  // Next-state, operand issue and accumulate logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q + addend;
    prod_d  = prod_q;
    vld_d   = 1'b0;
    sh_d    = '0;
    mul_a   = '0;
    mul_b   = '0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy  = 1'b1;
        mul_a = a_q[4*i_w +: 4];
        mul_b = b_q[4*j_w +: 4];
        vld_d = 1'b1;
        sh_d  = SW'({i_w + j_w, 2'b00});
        if (k_q == KW'(NPAIR - 1)) begin
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DRAIN: begin
        busy    = 1'b1;
        prod_d  = acc_d;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        k_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  // Valid/shift delay line matching the tile latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int t = 0; t < MUL_LAT; t++) begin
        sh_q[t] <= '0;
      end
    end else begin
      vld_q[0] <= vld_d;
      sh_q[0]  <= sh_d;
      for (int t = 1; t < MUL_LAT; t++) begin
        vld_q[t] <= vld_q[t-1];
        sh_q[t]  <= sh_q[t-1];
      end
    end
  end

endmodule

// File: tb/tb_nibble_mac_seq.sv
// Directed plus random checks of the nibble multiply sequencer
// against a plain arithmetic product model and a behavioural tile.
module tb_nibble_mac_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_p = '0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mul_p <= mul_a * mul_b;

  nibble_mac_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_p   (mul_p)
  );

  function automatic logic [63:0] model(input logic [31:0] a, b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic run_mul(input string tag,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input bit toggle);
    logic [63:0] prev;
    int n;
    bit bok;
    bit hold;
    prev  = product;
    n     = 0;
    bok   = 1;
    hold  = 1;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk);
      #1;
      if (toggle) start = 1'($urandom_range(0, 1));
      if (done) begin
        n = e;
        start = 1'b0;
        break;
      end
      if (!busy) bok = 0;
      if (product !== prev) hold = 0;
    end
    chk({tag, ":latency"}, 64'(n), 64'd65);
    chk({tag, ":product"}, product, model(a, b));
    chk({tag, ":busy_run"}, 64'(bok), 64'd1);
    chk({tag, ":held"}, 64'(hold), 64'd1);
    chk({tag, ":busy_done"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, ":done_pulse"}, 64'(done), 64'd0);
    chk({tag, ":busy_after"}, 64'(busy), 64'd0);
    chk({tag, ":product_kept"}, product, model(a, b));
  endtask

  logic [31:0] ra, rb;
  logic [63:0] m1, m2;
  int          n2;
  bit          hold2;

  initial begin
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    chk("rst_product", product, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_mul("3x5", 32'h0000_0003, 32'h0000_0005, 0);
    run_mul("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_mul("p16xp16", 32'h0001_0000, 32'h0001_0000, 0);
    run_mul("msbx2", 32'h8000_0000, 32'h0000_0002, 0);
    run_mul("zero", 32'h0000_0000, 32'hDEAD_BEEF, 1);
    for (int r = 0; r < 4; r++) begin
      ra = $urandom;
      rb = $urandom;
      run_mul($sformatf("rand%0d", r), ra, rb, r[0]);
    end

    op_a  = 32'hFFFF_FFFF;
    op_b  = 32'hFFFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("midrun_busy", 64'(busy), 64'd1);
    chk("midrun_mul_a", 64'(mul_a), 64'hF);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_mul_a", 64'(mul_a), 64'd0);
    chk("arst_mul_b", 64'(mul_b), 64'd0);
    chk("arst_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_mul("7x9", 32'd7, 32'd9, 0);

    ra    = $urandom;
    rb    = $urandom;
    m1    = model(ra, rb);
    op_a  = ra;
    op_b  = rb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n2 = 0;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n2 = e;
        break;
      end
    end
    chk("b2b1_latency", 64'(n2), 64'd65);
    chk("b2b1_product", product, m1);
    ra    = $urandom;
    rb    = $urandom;
    m2    = model(ra, rb);
    op_a  = ra;
    op_b  = rb;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_idle_busy", 64'(busy), 64'd0);
    chk("b2b_idle_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    chk("b2b2_busy", 64'(busy), 64'd1);
    n2    = 0;
    hold2 = 1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n2 = e;
        break;
      end
      if (product !== m1) hold2 = 0;
    end
    chk("b2b2_latency", 64'(n2), 64'd65);
    chk("b2b2_held", 64'(hold2), 64'd1);
    chk("b2b2_product", product, m2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/nibble_mac_seq.md
# nibble_mac_seq

Sequencer and accumulator that computes a WIDTH×WIDTH unsigned product by streaming nibble pairs through the existing 4×4 registered multiplier tile. It sits directly around that tile. It drives the tile's 4-bit operand inputs, consumes its registered 8-bit product one cycle later, and shift-adds each partial product into a 2·WIDTH accumulator. It is the bridge between the 4×4 tile and the 32-bit multiplier top level.

## Interface
Clock and reset: one clock; reset is asynchronous and active-low.

Parameters
- WIDTH, 32: operand width; must be a multiple of 4. NIB = WIDTH/4.

Ports
- clk  in  1: clock.
- rst_n  in  1: asynchronous active-low reset.
- start  in  1: request a multiply; sampled only in IDLE.
- op_a  in  WIDTH: multiplicand; latched when start is accepted.
- op_b  in  WIDTH: multiplier; latched when start is accepted.
- busy  out  1: high in RUN and DRAIN.
- done  out  1: one-cycle pulse when product is valid.
- product  out  2·WIDTH: result; held until the next accepted start.
- mul_a  out  4: operand nibble to the 4×4 tile.
- mul_b  out  4: operand nibble to the 4×4 tile.
- mul_p  in  8: registered 4×4 tile product, with 1-cycle latency.

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- **Reset values:** state = IDLE; busy, done, mul_a, mul_b = 0; product = 0; counters = 0; pipeline valid = 0.
- **IDLE:**
  - On start = 1: latch op_a and op_b, clear the accumulator, set pair index k = 0, and go to RUN.
  - start = 0 holds IDLE.
- **RUN:**
  - Pair k is decoded as i = k mod NIB and j = k / NIB.
  - Drive mul_a = A[4i+3:4i] and mul_b = B[4j+3:4j].
  - Register the shift amount s = 4·(i+j) and a valid flag alongside the issue, so they align with mul_p one cycle later.
  - When k = NIB²−1, go to DRAIN; otherwise increment k.
- **Accumulate:**
  - Each cycle that the delayed valid flag is set, do acc ← acc + (zero-extended mul_p << s_delayed).
  - The accumulator is 2·WIDTH bits. Partial sums never exceed the final product, so no overflow handling is needed.
- **DRAIN:**
  - One cycle; the last product is present on mul_p.
  - mul_a and mul_b return to 0.
  - Go to DONE; the final add happens at that edge.
- **DONE:**
  - done = 1 for one cycle and product = acc.
  - Go to IDLE.
- Start asserted outside IDLE is ignored; there is no queuing.
- A zero operand still runs the full sequence.
- Reset asserted mid-operation immediately returns all state to the reset values. Any in-flight tile output is discarded.

## Timing
- Edge E0 is start accepted.
- Pair k is presented during the cycle after edge Ek.
- The tile registers pair k's product at E(k+1).
- The accumulator adds it at E(k+2).
- The last pair (k = NIB²−1) is added at E(NIB²+1).
- done is high in the cycle after E(NIB²+1): 65 edges after start for WIDTH = 32.
- The earliest next start is accepted at E(NIB²+3), i.e. in the IDLE cycle following DONE.
- busy is high from the cycle after E0 through the DRAIN cycle inclusive.
- product changes only at the DONE transition (and on reset).

## Structure
- A shared package holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - the NIB and pair-count localparams;
  - the tile latency constant MUL_LAT = 1.
- The accumulator logic should reference MUL_LAT rather than a literal.
- No internal sub-module. The 4×4 tile is instantiated beside this block in the parent, with mul_a, mul_b and mul_p wired point-to-point.

## Test plan
- op_a = 0x00000003, op_b = 0x00000005, start pulse → done 65 edges later, product = 0x000000000000000F, busy low afterwards.
- op_a = op_b = 0xFFFFFFFF → product = 0xFFFFFFFE00000001.
- op_a = 0x00010000, op_b = 0x00010000 → product = 0x0000000100000000. Then op_a = 0x80000000, op_b = 0x00000002 → product = 0x0000000100000000.
- op_a = 0, op_b = 0xDEADBEEF → full 65-edge run, product = 0. Toggling start during RUN is ignored (exactly one done pulse).
- Reset mid-run: assert rst_n = 0 at pair 20 → busy, done, mul_a, mul_b and product all 0 immediately. After release, a new 7 × 9 multiply yields 0x3F.
- Back-to-back: the second start is held high from DONE → it is accepted in IDLE. The first product is held until the second done, and the second result is correct.
